// File: rtl/vd_pkg.sv
// Shared definitions for the keypad emulator: FSM state encoding, key_code
// field positions and the row one-hot helper.
package vd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int KEY_COL_LSB = 2;
    localparam int KEY_ROW_LSB = 0;
    localparam logic [1:0] COL_INVALID = 2'b11;

    function automatic logic [3:0] onehot4(input logic [1:0] row);
        onehot4 = 4'b0001 << row;
    endfunction

endpackage

// File: rtl/keypad_contact_model.sv
// Contact generator for one key press: bounce toggling, hold and release
// timing, reported as a contact level plus phase-end strobes to the FSM.
module keypad_contact_model
    import vd_pkg::*;
#(
    parameter int CW         = 24,
    parameter int BOUNCE_CYC = 64,
    parameter int BOUNCE_TGL = 8,
    parameter int HOLD_CYC   = 200000,
    parameter int GAP_CYC    = 70000
) (
    input  logic   fin,
    input  logic   rst,
    input  logic   start,
    input  state_t phase,
    output logic   contact,
    output logic   bounce_end,
    output logic   hold_end,
    output logic   gap_end
);

    // Terminal counts are clamped at zero so a zero-length phase still ends.
    localparam logic [CW-1:0] BOUNCE_LAST = (BOUNCE_CYC == 0) ? '0 : CW'(BOUNCE_CYC - 1);
    localparam logic [CW-1:0] TGL_LAST    = (BOUNCE_TGL <= 1) ? '0 : CW'(BOUNCE_TGL - 1);
    localparam logic [CW-1:0] HOLD_LAST   = (HOLD_CYC == 0)   ? '0 : CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST    = (GAP_CYC == 0)    ? '0 : CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    logic [CW-1:0] phase_cnt_r;
    logic [CW-1:0] press_cnt_r;
    logic [CW-1:0] tgl_cnt_r;
    logic          tgl_level_r;

    // Phase-end strobes and the contact level seen by the column drive.
    always_comb begin
        bounce_end = (phase == BOUNCE) && (phase_cnt_r >= BOUNCE_LAST);
        hold_end   = (phase == HOLD)   && (press_cnt_r >= HOLD_LAST);
        gap_end    = (phase == GAP)    && (phase_cnt_r >= GAP_LAST);
        case (phase)
            BOUNCE:  contact = tgl_level_r;
            HOLD:    contact = 1'b1;
            default: contact = 1'b0;
        endcase
    end

    // Phase, total-press and bounce-toggle counters; all saturate, none wrap.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            phase_cnt_r <= '0;
            press_cnt_r <= '0;
            tgl_cnt_r   <= '0;
            tgl_level_r <= 1'b0;
        end else if (start) begin
            phase_cnt_r <= '0;
            press_cnt_r <= '0;
            tgl_cnt_r   <= '0;
            tgl_level_r <= 1'b1;
        end else begin
            if (bounce_end || hold_end || gap_end) begin
                phase_cnt_r <= '0;
            end else if ((phase != IDLE) && (phase_cnt_r != CNT_MAX)) begin
                phase_cnt_r <= phase_cnt_r + CW'(1);
            end else begin
                phase_cnt_r <= phase_cnt_r;
            end
            // Press time spans bounce and hold, so HOLD_CYC includes the bounce.
            if (((phase == BOUNCE) || (phase == HOLD)) && (press_cnt_r != CNT_MAX)) begin
                press_cnt_r <= press_cnt_r + CW'(1);
            end else begin
                press_cnt_r <= press_cnt_r;
            end
            if (phase == BOUNCE) begin
                if (tgl_cnt_r >= TGL_LAST) begin
                    tgl_cnt_r   <= '0;
                    tgl_level_r <= ~tgl_level_r;
                end else begin
                    tgl_cnt_r   <= tgl_cnt_r + CW'(1);
                    tgl_level_r <= tgl_level_r;
                end
            end else begin
                tgl_cnt_r   <= tgl_cnt_r;
                tgl_level_r <= tgl_level_r;
            end
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 4x3 matrix keypad contact emulator: presses one requested key with bounce,
// holds it, releases it, and answers the row scan on the column lines.
module keypad_emulator
    import vd_pkg::*;
#(
    parameter int CW         = 24,
    parameter int BOUNCE_CYC = 64,
    parameter int BOUNCE_TGL = 8,
    parameter int HOLD_CYC   = 200000,
    parameter int GAP_CYC    = 70000,
    parameter int MIN_HITS   = 2
) (
    input  logic       fin,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] key_code,
    input  logic [3:0] scan,
    output logic [2:0] colum,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CW-1:0] HITS_MAX = '1;
    localparam logic [CW-1:0] HITS_MIN = CW'(MIN_HITS);

    state_t        state_r;
    logic [3:0]    key_r;
    logic [CW-1:0] hits_r;
    logic          gated_prev_r;

    logic          start_s;
    logic          contact_s;
    logic          bounce_end_s;
    logic          hold_end_s;
    logic          gap_end_s;
    logic [1:0]    col_sel_s;
    logic [1:0]    row_sel_s;
    logic          gated_s;
    logic          rise_s;
    logic [CW-1:0] hits_next_s;
    logic [2:0]    colum_next_s;

    keypad_contact_model #(
        .CW         (CW),
        .BOUNCE_CYC (BOUNCE_CYC),
        .BOUNCE_TGL (BOUNCE_TGL),
        .HOLD_CYC   (HOLD_CYC),
        .GAP_CYC    (GAP_CYC)
    ) u_contact (
        .fin        (fin),
        .rst        (rst),
        .start      (start_s),
        .phase      (state_r),
        .contact    (contact_s),
        .bounce_end (bounce_end_s),
        .hold_end   (hold_end_s),
        .gap_end    (gap_end_s)
    );

    // Request acceptance, row match against the scan and the next column value.
    always_comb begin
        col_sel_s = key_r[KEY_COL_LSB +: 2];
        row_sel_s = key_r[KEY_ROW_LSB +: 2];
        // The done cycle is already IDLE, so it is excluded explicitly.
        start_s   = (state_r == IDLE) && req && !done &&
                    (key_code[KEY_COL_LSB +: 2] != COL_INVALID);
        gated_s   = contact_s && (scan == onehot4(row_sel_s));
        rise_s    = gated_s && !gated_prev_r;
        if (rise_s && (hits_r != HITS_MAX)) begin
            hits_next_s = hits_r + CW'(1);
        end else begin
            hits_next_s = hits_r;
        end
        if (gated_s) begin
            case (col_sel_s)
                2'd0:    colum_next_s = 3'b001;
                2'd1:    colum_next_s = 3'b010;
                2'd2:    colum_next_s = 3'b100;
                default: colum_next_s = 3'b000;
            endcase
        end else begin
            colum_next_s = 3'b000;
        end
    end

    // Registered column drive; lags the scan by one cycle.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            colum        <= 3'b000;
            gated_prev_r <= 1'b0;
        end else begin
            colum        <= colum_next_s;
            gated_prev_r <= gated_s;
        end
    end

    // Press sequencer with hit counting and the busy/done/err flags.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            key_r   <= 4'b0000;
            hits_r  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        key_r   <= key_code;
                        hits_r  <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= (BOUNCE_CYC == 0) ? HOLD : BOUNCE;
                    end else if (req && !done) begin
                        err <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BOUNCE: begin
                    hits_r <= hits_next_s;
                    if (bounce_end_s) begin
                        state_r <= HOLD;
                    end else begin
                        state_r <= BOUNCE;
                    end
                end
                HOLD: begin
                    hits_r <= hits_next_s;
                    if (hold_end_s) begin
                        state_r <= GAP;
                        if (hits_next_s < HITS_MIN) begin
                            err <= 1'b1;
                        end else begin
                            err <= err;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                GAP: begin
                    if (gap_end_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= GAP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one instance with bounce, one with a clean contact.
module tb_keypad_emulator;

    localparam int HOLD_C = 200;
    localparam int GAP_C  = 40;

    logic       fin = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [3:0] key_a, key_b, scan_a, scan_b;
    logic [2:0] colum_a, colum_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

    always #5 fin = ~fin;

    keypad_emulator #(
        .CW(24), .BOUNCE_CYC(64), .BOUNCE_TGL(8),
        .HOLD_CYC(HOLD_C), .GAP_CYC(GAP_C), .MIN_HITS(2)
    ) u_dut_a (
        .fin(fin), .rst(rst), .req(req_a), .key_code(key_a), .scan(scan_a),
        .colum(colum_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    keypad_emulator #(
        .CW(24), .BOUNCE_CYC(0), .BOUNCE_TGL(8),
        .HOLD_CYC(HOLD_C), .GAP_CYC(GAP_C), .MIN_HITS(2)
    ) u_dut_b (
        .fin(fin), .rst(rst), .req(req_b), .key_code(key_b), .scan(scan_b),
        .colum(colum_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    typedef struct packed {
        logic [3:0] scan;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl [12];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge fin);
        #1;
    endtask

    initial begin
        int nchg;
        int ndone;
        int nbad_col;
        int nbusy;
        logic [2:0] prev;
        logic       err_at_done;

        tbl[0]  = '{4'b0001, 3'b000};
        tbl[1]  = '{4'b0010, 3'b000};
        tbl[2]  = '{4'b0100, 3'b010};
        tbl[3]  = '{4'b1000, 3'b000};
        tbl[4]  = '{4'b0001, 3'b000};
        tbl[5]  = '{4'b0010, 3'b000};
        tbl[6]  = '{4'b0100, 3'b010};
        tbl[7]  = '{4'b1000, 3'b000};
        tbl[8]  = '{4'b0110, 3'b000};
        tbl[9]  = '{4'b0100, 3'b010};
        tbl[10] = '{4'b1111, 3'b000};
        tbl[11] = '{4'b0000, 3'b000};

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        key_a = 4'b0000; key_b = 4'b0000; scan_a = 4'b0000; scan_b = 4'b0000;

        // 1. reset state with the scan moving
        for (int i = 0; i < 4; i++) begin
            scan_a = 4'b0001 << i;
            scan_b = 4'b0001 << i;
            tick();
            check("reset_outputs", {colum_a, busy_a, done_a, err_a, colum_b, busy_b, done_b, err_b}, 32'd0);
        end
        rst = 1'b0;
        tick();
        check("after_reset", {colum_a, busy_a, done_a, err_a, colum_b, busy_b, done_b, err_b}, 32'd0);

        // 2. clean contact, key col1/row2, scan table
        scan_b = 4'b0000; key_b = 4'b0110; req_b = 1'b1;
        tick();
        req_b = 1'b0;
        check("t2_busy", {31'd0, busy_b}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            scan_b = tbl[i].scan;
            tick();
            check("t2_colum", {29'd0, colum_b}, {29'd0, tbl[i].exp});
        end
        ndone = 0; err_at_done = 1'b1;
        for (int e = 13; e < 300; e++) begin
            scan_b = 4'b0001 << (e % 4);
            tick();
            if (done_b) begin
                ndone++;
                err_at_done = err_b;
                check("t2_done_edge", e, HOLD_C + GAP_C);
            end
        end
        check("t2_done_count", ndone, 1);
        check("t2_err", {31'd0, err_at_done}, 32'd0);
        check("t2_idle", {31'd0, busy_b}, 32'd0);

        // 3. bounce, scan held on the key row, req held across done
        scan_a = 4'b0100; key_a = 4'b0110; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("t3_busy", {31'd0, busy_a}, 32'd1);
        nchg = 0; ndone = 0; prev = 3'b000;
        for (int e = 1; e <= 260; e++) begin
            req_a = (e >= 230 && e <= 241);
            tick();
            if (e == 1) check("t3_first_contact", {29'd0, colum_a}, 32'd2);
            if (e >= 2 && e <= 200 && colum_a !== prev) begin
                if (nchg < 8) check("t3_toggle_edge", e, 9 + 8 * nchg);
                nchg++;
            end
            prev = colum_a;
            if (e == 100) check("t3_hold_colum", {29'd0, colum_a}, 32'd2);
            if (e == 201) check("t3_release", {29'd0, colum_a}, 32'd0);
            if (done_a) begin
                ndone++;
                if (ndone == 1) begin
                    check("t3_done_edge", e, HOLD_C + GAP_C);
                    check("t3_err", {31'd0, err_a}, 32'd0);
                    check("t3_busy_clear", {31'd0, busy_a}, 32'd0);
                end
            end
            if (e == 242) check("t3_req_at_done_ignored", {31'd0, busy_a}, 32'd0);
        end
        req_a = 1'b0;
        check("t3_toggle_count", nchg, 8);
        check("t3_done_count", ndone, 1);

        // 4. invalid column index
        key_a = 4'b1100; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("t4_err", {31'd0, err_a}, 32'd1);
        check("t4_busy", {31'd0, busy_a}, 32'd0);
        check("t4_colum", {29'd0, colum_a}, 32'd0);
        tick();
        check("t4_busy_later", {31'd0, busy_a}, 32'd0);

        // 5. scan stuck away from the key row: no hits, err at hold exit
        key_a = 4'b0011; scan_a = 4'b0001; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("t5_err_cleared", {31'd0, err_a}, 32'd0);
        check("t5_busy", {31'd0, busy_a}, 32'd1);
        ndone = 0; nbad_col = 0;
        for (int e = 1; e <= 250; e++) begin
            tick();
            if (colum_a != 3'b000) nbad_col++;
            if (e == 199) check("t5_err_before_exit", {31'd0, err_a}, 32'd0);
            if (e == 200) check("t5_err_at_exit", {31'd0, err_a}, 32'd1);
            if (done_a) ndone++;
        end
        check("t5_colum_quiet", nbad_col, 0);
        check("t5_done_count", ndone, 1);

        // 6. req while busy ignored, then reset mid-hold
        key_a = 4'b0110; scan_a = 4'b0100; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        for (int e = 1; e <= 80; e++) tick();
        key_a = 4'b0000; req_a = 1'b1;
        tick();
        req_a = 1'b0; key_a = 4'b0110;
        tick();
        check("t6_busy_req_ignored", {29'd0, colum_a}, 32'd2);
        check("t6_still_busy", {31'd0, busy_a}, 32'd1);
        for (int e = 0; e < 30; e++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_colum", {29'd0, colum_a}, 32'd0);
        check("t6_async_busy", {31'd0, busy_a}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        ndone = 0; nbusy = 0;
        for (int e = 0; e < 300; e++) begin
            tick();
            if (done_a) ndone++;
            if (busy_a) nbusy++;
        end
        check("t6_no_done", ndone, 0);
        check("t6_idle_after_reset", nbusy, 0);
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("t6_new_req", {31'd0, busy_a}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
